// File: rtl/clk_cfg_seq.sv
// clk_cfg_seq: runtime PLL sequencer on the reference clock.
// Gates the clocks, bypasses, loads FBDIV, waits for lock, then ungates.
module clk_cfg_seq #(
  parameter int FBDIV_WIDTH = 5,
  parameter int DEF_FBDIV   = 10,
  parameter int GATE_CYC    = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int LOCK_STABLE = 32,
  parameter int LOCK_TMO    = 4096,
  parameter int CNT_WIDTH   = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   I_CfgVld,
  output logic                   O_CfgRdy,
  input  logic [FBDIV_WIDTH-1:0] I_CfgFBDIV,
  input  logic                   I_CfgByp,
  input  logic                   I_PLLLock,
  output logic                   O_BypPLL,
  output logic [FBDIV_WIDTH-1:0] O_FBDIV,
  output logic                   O_SwClk,
  output logic                   O_CfgDone,
  output logic                   O_CfgErr,
  output logic                   O_LockLost
);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_WIDTH-1:0] GATE_END = CNT_WIDTH'(GATE_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] SETL_END = CNT_WIDTH'(SETTLE_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_END  = CNT_WIDTH'(LOCK_TMO - 1);
  localparam logic [SW-1:0]        STAB_END = SW'(LOCK_STABLE - 1);
  localparam logic [FBDIV_WIDTH-1:0] DEF_FB = FBDIV_WIDTH'(DEF_FBDIV);

  typedef enum logic [2:0] {
    S_IDLE, S_GATE, S_BYP, S_LOAD,
    S_LOCK, S_UNGATE, S_DONE, S_ERR
  } state_t;

  state_t                 r_state, w_state_n;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_n;
  logic [SW-1:0]          r_stab, w_stab_n;
  logic [1:0]             r_sync;
  logic [FBDIV_WIDTH-1:0] r_cap_fb, w_cap_fb_n;
  logic [FBDIV_WIDTH-1:0] r_fbdiv, w_fbdiv_n;
  logic                   r_cap_byp, w_cap_byp_n;
  logic                   r_byp, w_byp_n;
  logic                   r_sw, w_sw_n;
  logic                   r_err, w_err_n;
  logic                   r_ll, w_ll_n;
  logic                   w_lock, w_acc, w_bad;

  assign w_lock     = r_sync[1];
  assign O_CfgRdy   = (r_state == S_IDLE) || (r_state == S_ERR);
  assign w_acc      = I_CfgVld && O_CfgRdy;
  assign w_bad      = (I_CfgFBDIV == '0) && !I_CfgByp;
  assign O_BypPLL   = r_byp;
  assign O_FBDIV    = r_fbdiv;
  assign O_SwClk    = r_sw;
  assign O_CfgDone  = (r_state == S_DONE);
  assign O_CfgErr   = r_err;
  assign O_LockLost = r_ll;

  always_comb begin
    w_state_n   = r_state;
    w_stab_n    = '0;
    w_cap_fb_n  = r_cap_fb;
    w_cap_byp_n = r_cap_byp;
    w_fbdiv_n   = r_fbdiv;
    w_byp_n     = r_byp;
    w_sw_n      = r_sw;
    w_err_n     = r_err;
    w_ll_n      = r_ll;
    unique case (r_state)
      S_IDLE, S_ERR: begin
        if (r_state == S_ERR && r_cnt == GATE_END)
          w_sw_n = 1'b1;
        if (r_state == S_IDLE && !r_byp && !w_lock)
          w_ll_n = 1'b1;
        if (w_acc) begin
          w_err_n = w_bad;
          w_ll_n  = 1'b0;
          if (w_bad) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n   = S_GATE;
            w_sw_n      = 1'b0;
            w_cap_fb_n  = I_CfgFBDIV;
            w_cap_byp_n = I_CfgByp;
          end
        end
      end
      S_GATE: begin
        if (r_cnt == GATE_END) begin
          w_state_n = S_BYP;
          w_byp_n   = 1'b1;
        end
      end
      S_BYP: begin
        if (r_cnt == GATE_END)
          w_state_n = S_LOAD;
      end
      S_LOAD: begin
        // Held every LOAD cycle so the boot pass picks up the defaults too
        w_fbdiv_n = r_cap_fb;
        w_byp_n   = r_cap_byp;
        if (r_cnt == SETL_END)
          w_state_n = r_cap_byp ? S_UNGATE : S_LOCK;
      end
      S_LOCK: begin
        if (w_lock)
          w_stab_n = r_stab + 1'b1;
        if (w_lock && r_stab == STAB_END) begin
          w_state_n = S_UNGATE;
        end else if (r_cnt == TMO_END) begin
          w_state_n = S_ERR;
          w_byp_n   = 1'b1;
          w_err_n   = 1'b1;
        end
      end
      S_UNGATE: begin
        if (r_cnt == GATE_END) begin
          w_state_n = S_DONE;
          w_sw_n    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
    endcase
    w_cnt_n = (w_state_n != r_state) ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_stab    <= '0;
      r_sync    <= '0;
      r_cap_fb  <= DEF_FB;
      r_cap_byp <= 1'b0;
      r_fbdiv   <= DEF_FB;
      r_byp     <= 1'b1;
      r_sw      <= 1'b0;
      r_err     <= 1'b0;
      r_ll      <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_stab    <= w_stab_n;
      r_sync    <= {r_sync[0], I_PLLLock};
      r_cap_fb  <= w_cap_fb_n;
      r_cap_byp <= w_cap_byp_n;
      r_fbdiv   <= w_fbdiv_n;
      r_byp     <= w_byp_n;
      r_sw      <= w_sw_n;
      r_err     <= w_err_n;
      r_ll      <= w_ll_n;
    end
  end

endmodule

// File: tb/tb_clk_cfg_seq.sv
// tb_clk_cfg_seq: directed stimulus with a queued scoreboard of
// completion/error events checked by an independent monitor.
module tb_clk_cfg_seq;

  logic       clk;
  logic       rst;
  logic       I_CfgVld;
  logic       O_CfgRdy;
  logic [4:0] I_CfgFBDIV;
  logic       I_CfgByp;
  logic       I_PLLLock;
  logic       O_BypPLL;
  logic [4:0] O_FBDIV;
  logic       O_SwClk;
  logic       O_CfgDone;
  logic       O_CfgErr;
  logic       O_LockLost;

  clk_cfg_seq dut (
    .clk        (clk),
    .rst        (rst),
    .I_CfgVld   (I_CfgVld),
    .O_CfgRdy   (O_CfgRdy),
    .I_CfgFBDIV (I_CfgFBDIV),
    .I_CfgByp   (I_CfgByp),
    .I_PLLLock  (I_PLLLock),
    .O_BypPLL   (O_BypPLL),
    .O_FBDIV    (O_FBDIV),
    .O_SwClk    (O_SwClk),
    .O_CfgDone  (O_CfgDone),
    .O_CfgErr   (O_CfgErr),
    .O_LockLost (O_LockLost)
  );

  typedef struct {
    int         cyc;
    bit         kind;
    logic [4:0] fb;
    bit         byp;
    bit         sw;
    bit         err;
  } ev_t;

  ev_t sbq[$];
  ev_t m_e;
  int  n_run  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  bit  prev_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input int t);
    goto(t);
    @(negedge clk);
  endtask

  task automatic expect_ev(input int c, input bit k, input logic [4:0] fb,
                           input bit byp, input bit sw, input bit err);
    sbq.push_back('{cyc: c, kind: k, fb: fb, byp: byp, sw: sw, err: err});
  endtask

  task automatic req(input logic [4:0] fb, input logic byp);
    I_CfgVld   = 1'b1;
    I_CfgFBDIV = fb;
    I_CfgByp   = byp;
    goto(cyc + 1);
    I_CfgVld   = 1'b0;
    I_CfgFBDIV = '0;
    I_CfgByp   = 1'b0;
  endtask

  // Monitor: a Done pulse or a rising Err is a DUT response
  always @(negedge clk) begin
    if (O_CfgDone === 1'b1 || (O_CfgErr === 1'b1 && !prev_err)) begin
      if (sbq.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL sb_unexpected: got event at cyc %0d want none", cyc);
      end else begin
        m_e = sbq.pop_front();
        chk("ev_kind", {31'd0, O_CfgDone !== 1'b1}, {31'd0, m_e.kind});
        chk("ev_cyc", cyc, m_e.cyc);
        chk(m_e.kind ? "err_out" : "done_out",
            {O_FBDIV, O_BypPLL, O_SwClk, O_CfgErr},
            {m_e.fb, m_e.byp, m_e.sw, m_e.err});
      end
    end
    prev_err = (O_CfgErr === 1'b1);
  end

  initial begin
    int t0;
    int r;
    rst        = 1'b1;
    I_CfgVld   = 1'b0;
    I_CfgFBDIV = '0;
    I_CfgByp   = 1'b0;
    I_PLLLock  = 1'b0;

    peek(2);
    chk("rst_byp",   O_BypPLL,   1);
    chk("rst_fbdiv", O_FBDIV,    10);
    chk("rst_sw",    O_SwClk,    0);
    chk("rst_done",  O_CfgDone,  0);
    chk("rst_err",   O_CfgErr,   0);
    chk("rst_ll",    O_LockLost, 0);
    chk("rst_rdy",   O_CfgRdy,   0);

    // Boot: LOAD 16 + sync 2 + stable 32 + ungate 8 after lock drive
    goto(3);
    t0  = cyc;
    rst = 1'b0;
    expect_ev(t0 + 82, 0, 10, 0, 1, 0);
    peek(t0 + 1);
    chk("boot_fbdiv", O_FBDIV,  10);
    chk("boot_byp",   O_BypPLL, 0);
    chk("boot_sw",    O_SwClk,  0);
    goto(t0 + 40);
    I_PLLLock = 1'b1;
    peek(t0 + 81);
    chk("boot_sw_pre", O_SwClk, 0);
    goto(t0 + 85);

    // Reconfig to FBDIV=20
    r = cyc;
    I_PLLLock = 1'b0;
    expect_ev(r + 82, 0, 20, 0, 1, 0);
    req(20, 0);
    peek(r + 5);
    chk("gate_sw",  O_SwClk,  0);
    chk("gate_byp", O_BypPLL, 0);
    peek(r + 12);
    chk("byp_byp",   O_BypPLL, 1);
    chk("byp_fbdiv", O_FBDIV,  10);
    peek(r + 20);
    chk("load_fbdiv", O_FBDIV,  20);
    chk("load_byp",   O_BypPLL, 0);
    chk("load_sw",    O_SwClk,  0);
    goto(r + 40);
    I_PLLLock = 1'b1;
    peek(r + 83);
    chk("done_pulse", O_CfgDone, 0);
    chk("idle_rdy",   O_CfgRdy,  1);
    goto(r + 85);

    // Lock timeout
    r = cyc;
    I_PLLLock = 1'b0;
    expect_ev(r + 4129, 1, 12, 1, 0, 1);
    req(12, 0);
    peek(r + 4128);
    chk("tmo_err_pre", O_CfgErr, 0);
    peek(r + 4136);
    chk("err_sw_pre", O_SwClk, 0);
    peek(r + 4137);
    chk("err_sw",  O_SwClk,  1);
    chk("err_rdy", O_CfgRdy, 1);
    goto(r + 4140);

    // Bypass request from ERR: no LOCK phase
    r = cyc;
    expect_ev(r + 41, 0, 5, 1, 1, 0);
    req(5, 1);
    peek(r + 1);
    chk("byp_err_clr", O_CfgErr, 0);
    chk("byp_sw_gate", O_SwClk,  0);
    goto(r + 45);

    // Illegal FBDIV=0 without bypass
    r = cyc;
    expect_ev(r + 1, 1, 5, 1, 1, 1);
    req(0, 0);
    peek(r + 2);
    chk("ill_rdy",   O_CfgRdy,   1);
    chk("ill_fbdiv", O_FBDIV,    5);
    chk("ill_ll",    O_LockLost, 0);
    goto(r + 5);

    // Lock glitch after 20 high cycles, plus a request while busy
    r = cyc;
    expect_ev(r + 103, 0, 20, 0, 1, 0);
    req(20, 0);
    peek(r + 1);
    chk("gl_err_clr", O_CfgErr, 0);
    goto(r + 40);
    I_PLLLock = 1'b1;
    goto(r + 50);
    I_CfgVld   = 1'b1;
    I_CfgFBDIV = 5'd3;
    I_CfgByp   = 1'b1;
    @(negedge clk);
    chk("busy_rdy", O_CfgRdy, 0);
    goto(r + 51);
    I_CfgVld   = 1'b0;
    I_CfgFBDIV = '0;
    I_CfgByp   = 1'b0;
    goto(r + 60);
    I_PLLLock = 1'b0;
    goto(r + 61);
    I_PLLLock = 1'b1;
    peek(r + 102);
    chk("gl_sw_pre", O_SwClk, 0);
    goto(r + 110);
    I_PLLLock = 1'b0;
    goto(r + 111);
    I_PLLLock = 1'b1;
    peek(r + 112);
    chk("ll_pre", O_LockLost, 0);
    peek(r + 113);
    chk("ll_set", O_LockLost, 1);
    goto(r + 115);

    // Reset in the middle of LOAD restarts the boot sequence
    r = cyc;
    req(7, 0);
    peek(r + 1);
    chk("rl_ll_clr", O_LockLost, 0);
    peek(r + 20);
    chk("rl_fbdiv", O_FBDIV, 7);
    rst = 1'b1;
    peek(r + 21);
    chk("rl_byp",   O_BypPLL, 1);
    chk("rl_fbdef", O_FBDIV,  10);
    chk("rl_sw",    O_SwClk,  0);
    chk("rl_rdy",   O_CfgRdy, 0);
    goto(r + 22);
    rst = 1'b0;
    t0  = cyc;
    expect_ev(t0 + 56, 0, 10, 0, 1, 0);
    peek(t0 + 1);
    chk("rb_fbdiv", O_FBDIV,  10);
    chk("rb_byp",   O_BypPLL, 0);
    goto(t0 + 60);

    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
